// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer stages: Gray/binary conversion and defaults.
// The conversions work at a fixed maximum width; callers zero-extend and truncate to their own width.
package fifo_pkg;

  localparam int ADRRSIZE_DEF = 3;
  localparam int PTR_MAX      = 32;

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits leave the prefix XOR unaffected, so any narrower width converts correctly.
  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync_r2w.sv
// Two-flop synchroniser bringing the Gray read pointer into the write clock domain.
module fifo_sync_r2w #(
  parameter int W = 4
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic [W-1:0] rptr_gray,
  output logic [W-1:0] wq2_rptr
);

  logic [W-1:0] sync_p0;

  // first flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      sync_p0  <= '0;
      wq2_rptr <= '0;
    end else begin
      sync_p0  <= rptr_gray;
      wq2_rptr <= sync_p0;
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full / almost-full / level / sticky-overflow status of the async FIFO.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADRRSIZE     = ADRRSIZE_DEF,
  parameter int AFULL_THRESH = 6
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADRRSIZE:0]   rptr_gray,
  input  logic                woverflow_clr,
  output logic                wen,
  output logic [ADRRSIZE-1:0] waddr,
  output logic [ADRRSIZE:0]   wptr_gray,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADRRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int PW = ADRRSIZE + 1;
  localparam int A  = ADRRSIZE;
  localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);

  logic [PW-1:0] wptr_bin;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] wq2_rptr;
  logic [PW-1:0] rq2_bin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_cmp;

  fifo_sync_r2w #(.W(PW)) u_sync (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .rptr_gray (rptr_gray),
    .wq2_rptr  (wq2_rptr)
  );

  // Reset also masks the enable so memory is never written while pointers are held at 0.
  assign wen        = winc & ~wfull & wrst_n;
  assign waddr      = wptr_bin[ADRRSIZE-1:0];
  assign bin_next   = wptr_bin + PW'(wen);
  assign gray_next  = PW'(bin2gray(PTR_MAX'(bin_next)));
  assign rq2_bin    = PW'(gray2bin(PTR_MAX'(wq2_rptr)));
  assign level_next = bin_next - rq2_bin;
  // Full when write is one lap ahead: top two Gray bits inverted, the rest equal.
  assign full_cmp   = {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]};

  // status registers, evaluated against the stale synchronised read pointer
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_bin     <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wptr_bin     <= bin_next;
      wptr_gray    <= gray_next;
      wfull        <= (gray_next == full_cmp);
      walmost_full <= (level_next >= AF_T);
      wlevel       <= level_next;
      if (winc && wfull) begin
        woverflow <= 1'b1;
      end else if (woverflow_clr) begin
        woverflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: occupancy-count reference model feeding an expected-result queue.
module tb_fifo_wptr_full;

  typedef struct packed {
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] gray;
    logic       full;
    logic       af;
    logic [3:0] level;
    logic       ovf;
  } obs_t;

  logic       wclk = 1'b0;
  logic       clk_en = 1'b0;
  logic       wrst_n;
  logic       winc;
  logic [3:0] rptr_gray;
  logic       woverflow_clr;
  logic       wen;
  logic [2:0] waddr;
  logic [3:0] wptr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       woverflow;

  int checks = 0;
  int errors = 0;

  obs_t exp_q[$];
  obs_t act_q[$];
  obs_t last_act;

  int   m_wr, m_rd_in, m_s1, m_s2;
  logic m_full, m_ovf;

  fifo_wptr_full #(.ADRRSIZE(3), .AFULL_THRESH(6)) dut (
    .wclk          (wclk),
    .wrst_n        (wrst_n),
    .winc          (winc),
    .rptr_gray     (rptr_gray),
    .woverflow_clr (woverflow_clr),
    .wen           (wen),
    .waddr         (waddr),
    .wptr_gray     (wptr_gray),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .wlevel        (wlevel),
    .woverflow     (woverflow)
  );

  always #5 if (clk_en) wclk = ~wclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] gray4(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic m_reset();
    m_wr = 0; m_rd_in = 0; m_s1 = 0; m_s2 = 0; m_full = 1'b0; m_ovf = 1'b0;
  endtask

  // One write-clock cycle starting at a negedge: predict, step the clock, capture.
  task automatic drive_cycle(input logic inc, input logic clr);
    obs_t e, a;
    int   nwr, occ;
    winc = inc; woverflow_clr = clr; rptr_gray = gray4(m_rd_in);
    #1;
    e.wen   = inc & ~m_full;
    e.waddr = 3'(m_wr % 8);
    a.wen   = wen;
    a.waddr = waddr;
    nwr     = (m_wr + (e.wen ? 1 : 0)) % 16;
    occ     = (nwr - m_s2 + 16) % 16;
    e.gray  = gray4(nwr);
    e.full  = (occ == 8);
    e.af    = (occ >= 6);
    e.level = 4'(occ);
    e.ovf   = (inc && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    @(posedge wclk);
    m_wr = nwr; m_full = e.full; m_ovf = e.ovf; m_s2 = m_s1; m_s1 = m_rd_in;
    @(negedge wclk);
    a.gray = wptr_gray; a.full = wfull; a.af = walmost_full; a.level = wlevel; a.ovf = woverflow;
    last_act = a;
    exp_q.push_back(e);
    act_q.push_back(a);
  endtask

  task automatic reset_dut();
    @(negedge wclk);
    winc = 1'b0; woverflow_clr = 1'b0; wrst_n = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    obs_t e, a;
    wrst_n = 1'b1; winc = 1'b0; woverflow_clr = 1'b0; rptr_gray = 4'h0;
    #3 wrst_n = 1'b0;
    #2;
    checks++;
    if ({wen, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow} !== 15'h0) begin
      errors++;
      $display("FAIL reset_noclk got %h exp 0", {wen, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow});
    end
    clk_en = 1'b1;
    repeat (2) @(negedge wclk);
    wrst_n = 1'b1;
    m_reset();
    repeat (3) drive_cycle(1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL sb_reset got %h exp %h", a, e); end
    end
  endtask

  task automatic test_fill();
    obs_t e, a;
    logic [3:0] gtab [8];
    gtab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 1'b0);
      checks++;
      if (last_act.waddr !== 3'(i) || last_act.gray !== gtab[i]) begin
        errors++;
        $display("FAIL fill_seq%0d got addr %h gray %h exp addr %h gray %h", i, last_act.waddr, last_act.gray, 3'(i), gtab[i]);
      end
      checks++;
      if (last_act.af !== (i >= 5)) begin
        errors++; $display("FAIL fill_af%0d got %b exp %b", i, last_act.af, (i >= 5));
      end
    end
    checks++;
    if (last_act.full !== 1'b1 || last_act.level !== 4'd8) begin
      errors++; $display("FAIL fill_full got full %b level %0d exp 1 8", last_act.full, last_act.level);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL sb_fill got %h exp %h", a, e); end
    end
  endtask

  task automatic test_overflow();
    obs_t e, a;
    drive_cycle(1'b1, 1'b0);
    checks++;
    if (last_act.wen !== 1'b0 || last_act.waddr !== 3'd0 || last_act.ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_set got wen %b addr %h ovf %b exp 0 0 1", last_act.wen, last_act.waddr, last_act.ovf);
    end
    drive_cycle(1'b1, 1'b1);
    checks++;
    if (last_act.ovf !== 1'b1) begin errors++; $display("FAIL ovf_setwins got %b exp 1", last_act.ovf); end
    drive_cycle(1'b0, 1'b1);
    checks++;
    if (last_act.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", last_act.ovf); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL sb_ovf got %h exp %h", a, e); end
    end
  endtask

  task automatic test_read_release();
    obs_t e, a;
    m_rd_in = 1;
    drive_cycle(1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0);
    checks++;
    if (last_act.full !== 1'b1) begin errors++; $display("FAIL rel_early got full %b exp 1", last_act.full); end
    drive_cycle(1'b0, 1'b0);
    checks++;
    if (last_act.full !== 1'b0 || last_act.level !== 4'd7 || last_act.af !== 1'b1) begin
      errors++;
      $display("FAIL rel_3clk got full %b level %0d af %b exp 0 7 1", last_act.full, last_act.level, last_act.af);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL sb_rel got %h exp %h", a, e); end
    end
  endtask

  task automatic test_wrap();
    obs_t e, a;
    reset_dut();
    for (int i = 0; i < 20; i++) begin
      m_rd_in = (m_wr == 0) ? 0 : (m_wr + 15) % 16;
      drive_cycle(1'b1, 1'b0);
      if (i >= 1) begin
        checks++;
        if (last_act.full !== 1'b0 || last_act.level < 4'd2 || last_act.level > 4'd4) begin
          errors++; $display("FAIL wrap_lvl%0d got full %b level %0d exp 0 in 2..4", i, last_act.full, last_act.level);
        end
      end
      if (i == 14 || i == 15) begin
        checks++;
        if (last_act.gray !== ((i == 14) ? 4'h8 : 4'h0)) begin
          errors++; $display("FAIL wrap_gray%0d got %h exp %h", i, last_act.gray, (i == 14) ? 4'h8 : 4'h0);
        end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL sb_wrap got %h exp %h", a, e); end
    end
  endtask

  task automatic test_reset_midburst();
    obs_t e, a;
    reset_dut();
    repeat (5) drive_cycle(1'b1, 1'b0);
    checks++;
    if (last_act.level !== 4'd5) begin errors++; $display("FAIL mid_level got %0d exp 5", last_act.level); end
    winc = 1'b1;
    #1 wrst_n = 1'b0;
    #1;
    checks++;
    if ({wen, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow} !== 15'h0) begin
      errors++;
      $display("FAIL mid_async got %h exp 0", {wen, waddr, wptr_gray, wfull, walmost_full, wlevel, woverflow});
    end
    @(negedge wclk);
    wrst_n = 1'b1; winc = 1'b0;
    m_reset();
    drive_cycle(1'b1, 1'b0);
    checks++;
    if (last_act.wen !== 1'b1 || last_act.waddr !== 3'd0 || last_act.gray !== 4'h1) begin
      errors++;
      $display("FAIL mid_first got wen %b addr %h gray %h exp 1 0 1", last_act.wen, last_act.waddr, last_act.gray);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL sb_mid got %h exp %h", a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_read_release();
    test_wrap();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
